// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared sizing helpers and divisor limits for clk_div_odd_even
package clk_div_pkg;

    localparam int CLKDIV_MIN_DIV = 2;
    localparam int CLKDIV_MAX_DIV = 1024;

    // Counter width: max(1, clog2(n)).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Cycles the posedge-only output stays high: floor(n/2).
    function automatic int high_len(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/clk_div_negedge_retimer.sv
// rtl/clk_div_negedge_retimer.sv - falling-edge flop with synchronous active-low clear
module clk_div_negedge_retimer (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(negedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/clk_div_odd_even.sv
// rtl/clk_div_odd_even.sv - integer clock divider, optional 50% duty for odd N via CLKDIV_DUTY50_EN
module clk_div_odd_even
    import clk_div_pkg::*;
#(
    parameter int DIVISOR = 3
) (
    input  logic rst,
    input  logic clk,
    output logic q
);

    localparam int W = cnt_width(DIVISOR);
    localparam int L = high_len(DIVISOR);
    localparam logic [W-1:0] CNT_LAST = W'(DIVISOR - 1);
    localparam logic [W-1:0] CNT_HIGH = W'(L);

    if (DIVISOR < CLKDIV_MIN_DIV || DIVISOR > CLKDIV_MAX_DIV) begin : g_bad_divisor
        $error("clk_div_odd_even: DIVISOR=%0d outside legal range %0d..%0d",
               DIVISOR, CLKDIV_MIN_DIV, CLKDIV_MAX_DIV);
    end

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;
    logic         q_pos;

    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end

    // q_pos is high while the count just loaded sits in 1..L, so the first
    // rise lands on the first edge after reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            q_pos <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            q_pos <= (cnt_next != '0) && (cnt_next <= CNT_HIGH);
        end
    end

`ifdef CLKDIV_DUTY50_EN
    if (DIVISOR % 2 == 1) begin : g_duty50
        logic q_neg;

        // Half-cycle delayed copy stretches the high phase to L+0.5 cycles.
        clk_div_negedge_retimer u_retimer (
            .clk (clk),
            .rst (rst),
            .d   (q_pos),
            .q   (q_neg)
        );

        assign q = q_pos | q_neg;
    end else begin : g_even
        assign q = q_pos;
    end
`else
    assign q = q_pos;
`endif

endmodule

// File: tb/tb_clk_div_odd_even.sv
// tb/tb_clk_div_odd_even.sv - scoreboard bench for clk_div_odd_even at N=3,4,5
module tb_clk_div_odd_even;

`ifdef CLKDIV_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    typedef struct {
        logic [2:0] q;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] qv;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   k      = 0;
    int   nval[3] = '{3, 4, 5};
    logic pos[3];
    logic neg[3];

    always #5 clk = ~clk;

    clk_div_odd_even #(.DIVISOR(3)) u_div3 (.rst(rst), .clk(clk), .q(qv[0]));
    clk_div_odd_even #(.DIVISOR(4)) u_div4 (.rst(rst), .clk(clk), .q(qv[1]));
    clk_div_odd_even #(.DIVISOR(5)) u_div5 (.rst(rst), .clk(clk), .q(qv[2]));

    function automatic logic model_q(input int i, input logic p, input logic n);
        if (DUTY50 && (nval[i] % 2 == 1)) return p | n;
        return p;
    endfunction

    // Reference model: k counts edges since release (E1 => k=1); pushes the
    // expected q for the sample after every rising and falling edge.
    initial begin
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            pos[i] = 1'b0;
            neg[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (!rst) k = 0;
            else      k++;
            for (int i = 0; i < 3; i++) begin
                int m;
                m = k % nval[i];
                pos[i] = (m >= 1) && (m <= nval[i] / 2);
                e.q[i] = model_q(i, pos[i], neg[i]);
            end
            e.tag = $sformatf("post-posedge k=%0d", k);
            sb.push_back(e);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                neg[i] = rst ? pos[i] : 1'b0;
                e.q[i] = model_q(i, pos[i], neg[i]);
            end
            e.tag = $sformatf("post-negedge k=%0d", k);
            sb.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 3; i++) begin
                    n_vec++;
                    if (qv[i] !== e.q[i]) begin
                        n_miss++;
                        $display("FAIL div%0d %s: q got %b expected %b at %0t",
                                 nval[i], e.tag, qv[i], e.q[i], $time);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (30) @(posedge clk);

        // Reset N=5 at the edge following the state cnt=2 (q high).
        guard = 0;
        while ((k % 5) != 2 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        n_vec++;
        if ((k % 5) != 2) begin
            n_miss++;
            $display("FAIL mid_reset_align: phase got %0d expected 2", k % 5);
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (30) @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
